// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder block.
package mem_responder_pkg;
    localparam int LAT_W = 4;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  mbe_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;
endpackage

// File: rtl/mem_responder_array.sv
// Word storage for mem_responder: one synchronous byte-enabled write port and
// one registered read port. Contents are deliberately not reset.
module mem_responder_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  word_t         i_wdata,
    input  mbe_t          i_mbe,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output word_t         o_rdata
);
    logic [3:0][7:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_mbe[b]) r_mem[i_waddr][b] <= i_wdata[8*b +: 8];
            end
        end
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: IDLE -> BUSY (LATENCY+1 cycles) -> RESP pulse.
// Define MEM_RESPONDER_ALIGN_CHECK_EN to add the mem_err output and error checks.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  word_t       mem_wdata,
    input  mbe_t        mem_mbe,
    output logic        mem_resp,
    output word_t       mem_rdata
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    ,
    output logic        mem_err
`endif
);
    localparam int AW = $clog2(DEPTH_WORDS);

    state_e           r_state;
    state_e           w_next;
    logic [LAT_W-1:0] r_cnt;
    logic [AW-1:0]    r_idx;
    word_t            r_wdata;
    mbe_t             r_mbe;
    logic             r_write;
    logic             r_err;
    logic             w_req;
    logic             w_err_in;
    logic             w_access;
    logic             w_we;
    logic             w_re;
    word_t            w_rd;
    logic             w_unused;

    assign w_req = mem_read | mem_write;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign w_err_in = (mem_address[1:0] != 2'b00) | (mem_read & mem_write);
    assign mem_err  = (r_state == RESP) & r_err;
`else
    assign w_err_in = 1'b0;
`endif

    // Address bits outside the word index are ignored by design.
    assign w_unused = ^{mem_address[31:AW+2], mem_address[1:0]};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_req) w_next = BUSY;
            BUSY:    if (r_cnt == '0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_mbe   <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_req) begin
                r_cnt   <= LAT_W'(LATENCY);
                r_idx   <= mem_address[2 +: AW];
                r_wdata <= mem_wdata;
                r_mbe   <= mem_mbe;
                r_write <= mem_write;
                r_err   <= w_err_in;
            end else if (r_state == BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // The access happens on the BUSY->RESP edge; an erroneous write is dropped.
    assign w_access = (r_state == BUSY) && (r_cnt == '0);
    assign w_we     = w_access & r_write & ~r_err;
    assign w_re     = w_access & ~r_write;

    mem_responder_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk    (clk),
        .i_we   (w_we),
        .i_waddr(r_idx),
        .i_wdata(r_wdata),
        .i_mbe  (r_mbe),
        .i_re   (w_re),
        .i_raddr(r_idx),
        .o_rdata(w_rd)
    );

    assign mem_resp  = (r_state == RESP);
    assign mem_rdata = (mem_resp && !r_write) ? w_rd : '0;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder (LATENCY=2 main instance, LATENCY=0 throughput instance).
module tb_mem_responder;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_address = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_mbe = '0;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        l0_read = 1'b0;
    logic        l0_resp;
    logic [31:0] l0_rdata;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    logic        mem_err;
    logic        l0_err;
`endif

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] ref_mem [256];
    logic [31:0] exp_q [$];
    logic        exp_err_q [$];
    logic        prev_resp = 1'b0;
    logic        mon_en = 1'b0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_mbe    (mem_mbe),
        .mem_resp   (mem_resp),
        .mem_rdata  (mem_rdata)
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        ,
        .mem_err    (mem_err)
`endif
    );

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (l0_read),
        .mem_write  (1'b0),
        .mem_address(32'h0),
        .mem_wdata  (32'h0),
        .mem_mbe    (4'h0),
        .mem_resp   (l0_resp),
        .mem_rdata  (l0_rdata)
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        ,
        .mem_err    (l0_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, act, exp);
    endtask

    // Response monitor: pops the scoreboard on every mem_resp pulse.
    always @(negedge clk) begin : mon
        logic [31:0] e;
        logic        ee;
        if (mon_en) begin
            if (mem_resp) begin
                chk("resp_one_cycle", 32'(prev_resp), 32'h0);
                if (exp_q.size() == 0) begin
                    chk("spurious_resp", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    ee = exp_err_q.pop_front();
                    chk("rdata", mem_rdata, e);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
                    chk("err", 32'(mem_err), 32'(ee));
`endif
                end
            end else begin
                chk("rdata_idle", mem_rdata, 32'h0);
            end
        end
        prev_resp = mem_resp;
    end

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] mbe);
        int          n;
        logic [7:0]  idx;
        logic        err;
        logic [31:0] exp;
        idx = addr[9:2];
        err = 1'b0;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        err = (addr[1:0] != 2'b00) || (rd && wr);
`endif
        exp = '0;
        if (wr) begin
            if (!err) begin
                for (int b = 0; b < 4; b++)
                    if (mbe[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
            end
        end else begin
            exp = ref_mem[idx];
        end
        @(negedge clk);
        exp_q.push_back(exp);
        exp_err_q.push_back(err);
        mem_read = rd;
        mem_write = wr;
        mem_address = addr;
        mem_wdata = wd;
        mem_mbe = mbe;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            // Scramble inputs after acceptance; the captured request must stand.
            if (n == 1) begin
                mem_address = ~addr;
                mem_wdata = ~wd;
                mem_mbe = ~mbe;
            end
        end while (!mem_resp && n < 20);
        chk("latency", 32'(n), 32'(LAT + 2));
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin : main
        int cnt;
        int last;
        logic l0_prev;
        logic [7:0] ridx;
        logic       rwr;

        foreach (ref_mem[i]) ref_mem[i] = '0;

        repeat (3) @(negedge clk);
        chk("rst_resp", 32'(mem_resp), 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        chk("rst_err", 32'(mem_err), 32'h0);
`endif
        rst = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 16; i++) do_req(1'b0, 1'b1, 32'(i * 4), 32'hA500_0000 | 32'(i), 4'hF);

        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        do_req(1'b0, 1'b1, 32'h10, 32'h000000AA, 4'h1);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        do_req(1'b0, 1'b1, 32'h400, 32'h11111111, 4'hF);
        do_req(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        do_req(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        do_req(1'b1, 1'b1, 32'h30, 32'h33333333, 4'hF);
        do_req(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
        do_req(1'b0, 1'b1, 32'h13, 32'h44444444, 4'hF);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);

        // Reset in BUSY aborts the write to 0x20.
        do_req(1'b0, 1'b1, 32'h20, 32'h55555555, 4'hF);
        @(negedge clk);
        mem_write = 1'b1;
        mem_address = 32'h20;
        mem_wdata = 32'h22222222;
        mem_mbe = 4'hF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        chk("abort_resp", 32'(mem_resp), 32'h0);
        chk("abort_rdata", mem_rdata, 32'h0);
        rst = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_resp) cnt++;
        end
        chk("abort_no_resp", 32'(cnt), 32'h0);
        do_req(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);

        for (int i = 0; i < 40; i++) begin
            ridx = 8'($urandom_range(0, 15));
            rwr = 1'($urandom_range(0, 1));
            do_req(!rwr, rwr, ($urandom() & 32'hFFFF_FC00) | {22'h0, ridx, 2'b00},
                   $urandom(), 4'($urandom_range(0, 15)));
        end

        // LATENCY=0 with a continuously held read: one pulse every 3 cycles.
        @(negedge clk);
        l0_read = 1'b1;
        cnt = 0;
        last = 0;
        l0_prev = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (l0_resp) begin
                chk("l0_consecutive", 32'(l0_prev), 32'h0);
                if (last != 0) chk("l0_gap", 32'(k - last), 32'h3);
                last = k;
                cnt++;
            end
            l0_prev = l0_resp;
        end
        chk("l0_count", 32'(cnt), 32'd10);
        l0_read = 1'b0;

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
